// File: rtl/fifo_pkg.sv
// Shared constants and the packer state type for the read-side byte packer.
package fifo_pkg;

  localparam int DATA_W = 8;
  localparam int PACK   = 4;
  localparam int CNT_W  = $clog2(PACK);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2
  } pack_state_e;

endpackage

// File: rtl/fifo_byte_packer_idle_timer.sv
// Saturating idle-cycle counter; expired fires on the idle cycle that brings the count to TIMEOUT.
module idle_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_rd,
  input  logic rrst_n,
  input  logic run,
  input  logic clr,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (run && (count_q != TW'(TIMEOUT))) begin
      count_d = count_q + TW'(1);
    end
  end

  // Counting includes the current idle cycle, so the flush decision lands on the TIMEOUT-th one.
  assign expired = run && !clr && (count_q >= TW'(TIMEOUT - 1));

  always_ff @(posedge clk_rd) begin
    if (!rrst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fifo_byte_packer.sv
// Pops bytes from the async FIFO read port and packs them little-endian into 32-bit words,
// flushing a stalled partial word after TIMEOUT idle cycles.
module fifo_byte_packer #(
  parameter int DATA_W  = fifo_pkg::DATA_W,
  parameter int PACK    = fifo_pkg::PACK,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk_rd,
  input  logic                   rrst_n,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic [DATA_W-1:0]      fifo_rd_data,
  output logic [PACK*DATA_W-1:0] out_data,
  output logic [2:0]             out_bytes,
  output logic                   out_valid,
  input  logic                   out_ready
);

  import fifo_pkg::*;

  localparam int ACC_W = (PACK - 1) * DATA_W;

  pack_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    inflight_q;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [PACK*DATA_W-1:0]  out_data_q, out_data_d;
  logic [2:0]              out_bytes_q, out_bytes_d;
  logic                    out_valid_q, out_valid_d;

  logic [2:0]              pend;
  logic                    flush_now;
  logic                    out_free;
  logic                    pop;
  logic                    complete;
  logic                    idle_run;
  logic                    idle_clr;
  logic                    idle_expired;
  logic                    flush_go;
  logic [PACK*DATA_W-1:0]  flush_word;

  assign pend      = 3'(cnt_q) + 3'(inflight_q);
  assign flush_now = (state_q == FLUSH);
  assign out_free  = !out_valid_q || out_ready;

  // A pop at pend == 3 completes a word one cycle later, so it needs the output register
  // to be empty or draining right now.
  assign pop = rrst_n && !fifo_empty && !flush_now &&
               ((pend < 3'd3) || ((pend == 3'd3) && out_free));

  assign complete = inflight_q && (cnt_q == CNT_W'(PACK - 1));

  assign idle_run = (cnt_q != '0) && !inflight_q && !pop;
  assign idle_clr = pop || inflight_q || flush_now;
  assign flush_go = idle_expired && (cnt_q != '0) && !inflight_q && out_free;

  idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk_rd  (clk_rd),
    .rrst_n  (rrst_n),
    .run     (idle_run),
    .clr     (idle_clr),
    .expired (idle_expired)
  );

  // Lanes beyond cnt may still hold bytes of an older word, so they are masked to zero.
  generate
    for (genvar gi = 0; gi < PACK - 1; gi++) begin : g_flush_lane
      assign flush_word[gi*DATA_W +: DATA_W] =
        (CNT_W'(gi) < cnt_q) ? acc_q[gi*DATA_W +: DATA_W] : '0;
    end
  endgenerate
  assign flush_word[PACK*DATA_W-1 -: DATA_W] = '0;

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_bytes_d = out_bytes_q;
    out_valid_d = out_valid_q;
    state_d     = state_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (inflight_q) begin
      if (complete) begin
        out_data_d  = {fifo_rd_data, acc_q};
        out_bytes_d = 3'(PACK);
        out_valid_d = 1'b1;
        cnt_d       = '0;
      end else begin
        for (int i = 0; i < PACK - 1; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            acc_d[i*DATA_W +: DATA_W] = fifo_rd_data;
          end
        end
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (flush_now) begin
      out_data_d  = flush_word;
      out_bytes_d = 3'(cnt_q);
      out_valid_d = 1'b1;
      cnt_d       = '0;
    end

    case (state_q)
      EMPTY: begin
        if (pop) begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (flush_go) begin
          state_d = FLUSH;
        end else if ((cnt_d == '0) && !pop) begin
          state_d = EMPTY;
        end
      end
      FLUSH: begin
        state_d = EMPTY;
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk_rd) begin
    if (!rrst_n) begin
      state_q     <= EMPTY;
      cnt_q       <= '0;
      inflight_q  <= 1'b0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_bytes_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      inflight_q  <= pop;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_bytes_q <= out_bytes_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign fifo_rd_en = pop;
  assign out_data   = out_data_q;
  assign out_bytes  = out_bytes_q;
  assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Scoreboard bench for fifo_byte_packer: a FIFO model feeds bytes, a monitor checks every word.
module tb_fifo_byte_packer;

  localparam int T = 16;

  logic        clk_rd = 1'b0;
  logic        rrst_n = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data = 8'h00;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic        out_valid;
  logic        out_ready = 1'b0;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  nb;
  } word_t;

  logic [7:0] fifo_q[$];
  word_t      exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int popped = 0;
  int accepted = 0;
  int word_no = 0;

  fifo_byte_packer #(
    .DATA_W  (8),
    .PACK    (4),
    .TIMEOUT (T)
  ) dut (
    .clk_rd       (clk_rd),
    .rrst_n       (rrst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .out_data     (out_data),
    .out_bytes    (out_bytes),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  always #5 clk_rd = ~clk_rd;

  initial forever begin
    @(posedge clk_rd);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: each burst is packed in arrival order, 4 bytes per word, remainder flushed as a short word.
  task automatic push_bytes(input logic [7:0] b[$], input bit scored);
    word_t w;
    for (int i = 0; i < b.size(); i++) begin
      fifo_q.push_back(b[i]);
    end
    if (scored) begin
      for (int i = 0; i < b.size(); i += 4) begin
        w = '0;
        for (int j = 0; j < 4 && (i + j) < b.size(); j++) begin
          w.data = w.data | (32'(b[i+j]) << (8 * j));
          w.nb   = w.nb + 3'd1;
        end
        exp_q.push_back(w);
      end
    end
  endtask

  // FIFO read port: data appears the cycle after a pop; empty reflects pushes made at +2.
  initial begin
    bit pop_now;
    forever begin
      @(negedge clk_rd);
      pop_now = fifo_rd_en && !fifo_empty;
      @(posedge clk_rd);
      #1;
      if (pop_now && fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
      #2;
      fifo_empty = (fifo_q.size() == 0);
    end
  end

  // Monitor: reset values, pending-byte bound, and scoreboard comparison of each transfer.
  initial begin
    bit    rst_low_prev;
    int    held;
    int    pend_est;
    word_t e;
    rst_low_prev = 1'b0;
    forever begin
      @(negedge clk_rd);
      if (!rrst_n) begin
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        if (rst_low_prev) begin
          check("rst_out_valid", 32'(out_valid), 32'd0);
          check("rst_out_data", out_data, 32'd0);
          check("rst_out_bytes", 32'(out_bytes), 32'd0);
        end
        popped   = 0;
        accepted = 0;
      end else begin
        held     = out_valid ? int'(out_bytes) : 0;
        pend_est = popped - accepted - held;
        checks++;
        if (pend_est < 0 || pend_est > 4) begin
          errors++;
          $display("FAIL pend_range: pend=%0d, allowed 0..4 (cycle %0d)", pend_est, cyc);
        end
        if (fifo_rd_en && !fifo_empty) popped++;
        if (out_valid && out_ready) begin
          accepted += int'(out_bytes);
          word_no++;
          $display("word %0d @cycle %0d: data=%08h bytes=%0d", word_no, cyc, out_data, out_bytes);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %08h/%0d, expected none", out_data, out_bytes);
          end else begin
            e = exp_q.pop_front();
            check("word_data", out_data, e.data);
            check("word_bytes", 32'(out_bytes), 32'(e.nb));
          end
        end
      end
      rst_low_prev = !rrst_n;
    end
  end

  task automatic at_cycle_start();
    @(posedge clk_rd);
    #2;
  endtask

  task automatic wait_pops(input int n, output int last);
    int k;
    k = 0;
    last = -1;
    for (int t = 0; t < 200 && k < n; t++) begin
      @(negedge clk_rd);
      if (fifo_rd_en && !fifo_empty) begin
        k++;
        last = cyc;
      end
    end
    if (k < n) begin
      checks++;
      errors++;
      $display("FAIL wait_pops: saw %0d pops, required %0d", k, n);
    end
  endtask

  task automatic wait_valid(output int v);
    v = -1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk_rd);
      if (out_valid) begin
        v = cyc;
        break;
      end
    end
    if (v < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: out_valid=0 after 200 cycles, required 1");
    end
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk_rd);
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: %0d words outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk_rd);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bq[$];
    int c, lp, v, n;

    rrst_n = 1'b0;
    repeat (3) at_cycle_start();
    rrst_n = 1'b1;
    at_cycle_start();
    check("reset_out_valid", 32'(out_valid), 32'd0);

    // Full word: 4 preloaded bytes, word seen 5 cycles after the first pop, for exactly one cycle.
    out_ready = 1'b1;
    bq = {8'h11, 8'h22, 8'h33, 8'h44};
    push_bytes(bq, 1'b1);
    wait_pops(1, c);
    wait_valid(v);
    check("full_latency", 32'(v - c), 32'd5);
    @(negedge clk_rd);
    check("full_one_cycle", 32'(out_valid), 32'd0);
    wait_drain("full");

    // Backpressure: 12 bytes, consumer stalls 10 cycles once the first word is up.
    at_cycle_start();
    out_ready = 1'b0;
    bq.delete();
    for (int i = 1; i <= 12; i++) bq.push_back(8'(i));
    push_bytes(bq, 1'b1);
    wait_valid(v);
    repeat (9) @(negedge clk_rd);
    check("bp_stall_rd_en", 32'(fifo_rd_en), 32'd0);
    at_cycle_start();
    out_ready = 1'b1;
    @(negedge clk_rd);
    check("bp_resume_rd_en", 32'(fifo_rd_en), 32'd1);
    wait_drain("bp");

    // Partial flush: last byte sampled at the edge closing cycle lp+1; word visible T+1 edges later.
    at_cycle_start();
    bq = {8'hAA, 8'hBB};
    push_bytes(bq, 1'b1);
    wait_pops(2, lp);
    wait_valid(v);
    check("flush_latency", 32'(v - lp), 32'(T + 3));
    check("flush_bytes", 32'(out_bytes), 32'd2);
    wait_drain("flush");

    // Flush/refill collision: FIFO refills during the FLUSH cycle (lp+T+2).
    at_cycle_start();
    bq = {8'h5A, 8'hC3};
    push_bytes(bq, 1'b1);
    wait_pops(2, lp);
    repeat (T + 2) @(posedge clk_rd);
    #2;
    bq = {8'h01, 8'h23, 8'h45, 8'h67};
    push_bytes(bq, 1'b1);
    @(negedge clk_rd);
    check("collide_rd_en_low", 32'(fifo_rd_en), 32'd0);
    @(negedge clk_rd);
    check("collide_rd_en_high", 32'(fifo_rd_en), 32'd1);
    check("collide_flush_valid", 32'(out_valid), 32'd1);
    check("collide_flush_bytes", 32'(out_bytes), 32'd2);
    wait_drain("collide");

    // Mid-word reset: 3 bytes held plus one in flight, reset 2 cycles, then a clean word.
    at_cycle_start();
    bq = {8'hE1, 8'hE2, 8'hE3, 8'hE4};
    push_bytes(bq, 1'b0);
    bq = {8'h10, 8'h20, 8'h30, 8'h40};
    push_bytes(bq, 1'b1);
    wait_pops(4, lp);
    at_cycle_start();
    rrst_n = 1'b0;
    at_cycle_start();
    @(negedge clk_rd);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", out_data, 32'd0);
    check("midrst_rd_en", 32'(fifo_rd_en), 32'd0);
    at_cycle_start();
    rrst_n = 1'b1;
    wait_drain("midrst");

    // Random bursts with random consumer readiness.
    for (int b = 0; b < 25; b++) begin
      bit done;
      at_cycle_start();
      n = $urandom_range(1, 13);
      bq.delete();
      for (int i = 0; i < n; i++) bq.push_back(8'($urandom_range(0, 255)));
      push_bytes(bq, 1'b1);
      done = 1'b0;
      for (int t = 0; t < 500; t++) begin
        at_cycle_start();
        out_ready = ($urandom_range(0, 3) != 0);
        if (exp_q.size() == 0 && fifo_q.size() == 0) begin
          done = 1'b1;
          break;
        end
      end
      if (!done) begin
        checks++;
        errors++;
        $display("FAIL rand_burst_%0d: %0d words outstanding, required 0", b, exp_q.size());
        exp_q.delete();
      end
      out_ready = 1'b1;
    end

    repeat (T + 8) at_cycle_start();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("fifo_drained", 32'(fifo_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
